// File: rtl/ex_wb_stage.sv
// EX->WB stage: 2-entry skid buffer feeding the register-file write port, plus taken-branch redirect.
// Define EX_WB_FWD_EN to add the fwd_* outputs that expose the youngest buffered write.
module ex_wb_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [DATA_WIDTH-1:0]     alu_result_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_i,
  input  logic                      we_i,
  input  logic                      is_branch_i,
  input  logic [ADDR_WIDTH-1:0]     branch_target_i,
  input  logic                      flush_i,
  output logic                      wb_valid_o,
  input  logic                      wb_ready_i,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd_o,
  output logic [DATA_WIDTH-1:0]     wb_data_o,
  output logic                      wb_we_o,
`ifdef EX_WB_FWD_EN
  output logic                      fwd_valid_o,
  output logic [REG_ADDR_WIDTH-1:0] fwd_rd_o,
  output logic [DATA_WIDTH-1:0]     fwd_data_o,
`endif
  output logic                      redirect_valid_o,
  output logic [ADDR_WIDTH-1:0]     redirect_pc_o
);

  logic                      r_out_vld, r_out_we;
  logic [REG_ADDR_WIDTH-1:0] r_out_rd;
  logic [DATA_WIDTH-1:0]     r_out_data;
  logic                      r_skid_vld, r_skid_we;
  logic [REG_ADDR_WIDTH-1:0] r_skid_rd;
  logic [DATA_WIDTH-1:0]     r_skid_data;
  logic                      r_in_ready;
  logic                      r_redir_vld;
  logic [ADDR_WIDTH-1:0]     r_redir_pc;

  logic w_acc, w_out_free, w_in_we, w_taken;

  assign w_acc      = in_valid_i && r_in_ready;
  assign w_out_free = !r_out_vld || wb_ready_i;
  // Branches never write back, and x0 is hardwired so writes to it are dropped here.
  assign w_in_we    = we_i && (rd_i != '0) && !is_branch_i;
  assign w_taken    = w_acc && is_branch_i && alu_result_i[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_vld   <= 1'b0;
      r_out_we    <= 1'b0;
      r_out_rd    <= '0;
      r_out_data  <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_we   <= 1'b0;
      r_skid_rd   <= '0;
      r_skid_data <= '0;
      r_in_ready  <= 1'b1;
      r_redir_vld <= 1'b0;
      r_redir_pc  <= '0;
    end else if (flush_i) begin
      r_out_vld   <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_redir_vld <= 1'b0;
    end else begin
      if (w_out_free) begin
        if (r_skid_vld) begin
          r_out_vld  <= 1'b1;
          r_out_we   <= r_skid_we;
          r_out_rd   <= r_skid_rd;
          r_out_data <= r_skid_data;
          r_skid_vld <= w_acc;
          r_in_ready <= !w_acc;
          if (w_acc) begin
            r_skid_we   <= w_in_we;
            r_skid_rd   <= rd_i;
            r_skid_data <= alu_result_i;
          end
        end else begin
          r_out_vld  <= w_acc;
          r_in_ready <= 1'b1;
          if (w_acc) begin
            r_out_we   <= w_in_we;
            r_out_rd   <= rd_i;
            r_out_data <= alu_result_i;
          end
        end
      end else if (w_acc) begin
        r_skid_vld  <= 1'b1;
        r_skid_we   <= w_in_we;
        r_skid_rd   <= rd_i;
        r_skid_data <= alu_result_i;
        r_in_ready  <= 1'b0;
      end
      r_redir_vld <= w_taken;
      if (w_taken) r_redir_pc <= branch_target_i;
    end
  end

  assign in_ready_o       = r_in_ready;
  assign wb_valid_o       = r_out_vld;
  assign wb_we_o          = r_out_we;
  assign wb_rd_o          = r_out_rd;
  assign wb_data_o        = r_out_data;
  assign redirect_valid_o = r_redir_vld;
  assign redirect_pc_o    = r_redir_pc;

`ifdef EX_WB_FWD_EN
  // Youngest entry wins; fields are zeroed when nothing forwardable is buffered.
  logic w_fwd_vld;
  assign w_fwd_vld   = r_skid_vld ? r_skid_we : (r_out_vld && r_out_we);
  assign fwd_valid_o = w_fwd_vld;
  assign fwd_rd_o    = !w_fwd_vld ? '0 : (r_skid_vld ? r_skid_rd : r_out_rd);
  assign fwd_data_o  = !w_fwd_vld ? '0 : (r_skid_vld ? r_skid_data : r_out_data);
`endif

endmodule

// File: tb/tb_ex_wb_stage.sv
// Bench for ex_wb_stage: directed test-plan checks plus randomized traffic against a queue model.
module tb_ex_wb_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, we, is_branch, flush, wb_ready;
  logic [31:0] alu_result, target;
  logic [4:0]  rd;
  logic        in_ready, wb_valid, wb_we, redir_vld;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, redir_pc;
`ifdef EX_WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  always #5 clk = ~clk;

  ex_wb_stage dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .alu_result_i(alu_result), .rd_i(rd), .we_i(we), .is_branch_i(is_branch),
    .branch_target_i(target), .flush_i(flush), .wb_valid_o(wb_valid),
    .wb_ready_i(wb_ready), .wb_rd_o(wb_rd), .wb_data_o(wb_data), .wb_we_o(wb_we),
`ifdef EX_WB_FWD_EN
    .fwd_valid_o(fwd_valid), .fwd_rd_o(fwd_rd), .fwd_data_o(fwd_data),
`endif
    .redirect_valid_o(redir_vld), .redirect_pc_o(redir_pc)
  );

  typedef struct { logic [4:0] rd; logic [31:0] data; logic we; } beat_t;
  beat_t       q[$];
  logic        m_redir_vld;
  logic [31:0] m_redir_pc;
  int          n_total = 0, n_pass = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
  endtask

  // Model: the stage is a FIFO of depth 2; in_ready reflects occupancy < 2.
  task automatic model_edge();
    bit acc, pop;
    beat_t b;
    if (rst) begin
      q.delete(); m_redir_vld = 1'b0; m_redir_pc = '0;
    end else if (flush) begin
      q.delete(); m_redir_vld = 1'b0;
    end else begin
      acc = in_valid && (q.size() < 2);
      pop = (q.size() > 0) && wb_ready;
      if (pop) void'(q.pop_front());
      if (acc) begin
        b.rd = rd; b.data = alu_result; b.we = we && (rd != 0) && !is_branch;
        q.push_back(b);
      end
      m_redir_vld = acc && is_branch && alu_result[0];
      if (m_redir_vld) m_redir_pc = target;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    chk_en = 1'b1;
    #2;
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("in_ready", in_ready, q.size() < 2);
    chk("wb_valid", wb_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("wb_rd", wb_rd, q[0].rd);
      chk("wb_data", wb_data, q[0].data);
      chk("wb_we", wb_we, q[0].we);
    end
    chk("redir_vld", redir_vld, m_redir_vld);
    chk("redir_pc", redir_pc, m_redir_pc);
`ifdef EX_WB_FWD_EN
    begin
      bit fv;
      fv = (q.size() > 0) && q[q.size()-1].we;
      chk("fwd_valid", fwd_valid, fv);
      chk("fwd_rd", fwd_rd, fv ? q[q.size()-1].rd : 5'd0);
      chk("fwd_data", fwd_data, fv ? q[q.size()-1].data : 32'd0);
    end
`endif
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] r,
                       input logic w, input logic br, input logic [31:0] t);
    in_valid = v; alu_result = d; rd = r; we = w; is_branch = br; target = t;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wb_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    cycle(); cycle();
    chk("rst_in_ready", in_ready, 1); chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_we", wb_we, 0); chk("rst_wb_rd", wb_rd, 0); chk("rst_wb_data", wb_data, 0);
    chk("rst_redir", redir_vld, 0); chk("rst_pc", redir_pc, 0);

    rst = 1'b0; drive(1, 32'h5, 3, 1, 0, 0);
    cycle();
    chk("t1_valid", wb_valid, 1); chk("t1_rd", wb_rd, 3); chk("t1_data", wb_data, 5);
    chk("t1_we", wb_we, 1); chk("t1_ready", in_ready, 1);
    drive(0, 0, 0, 0, 0, 0); cycle();

    // Backpressure: A and B fill the buffer, C waits.
    wb_ready = 1'b0;
    drive(1, 32'h11, 1, 1, 0, 0); cycle();
    drive(1, 32'h22, 2, 1, 0, 0); cycle();
    chk("bp_ready_low", in_ready, 0);
    drive(1, 32'h33, 4, 1, 0, 0); cycle();
    chk("bp_hold_A", wb_data, 32'h11); chk("bp_ready_low2", in_ready, 0);
    wb_ready = 1'b1; cycle();
    chk("bp_B", wb_data, 32'h22);
    cycle();
    chk("bp_C", wb_data, 32'h33);
    drive(0, 0, 0, 0, 0, 0); cycle();
    chk("bp_drained", wb_valid, 0);

    drive(1, 32'hDEADBEEF, 0, 1, 0, 0); cycle();
    chk("x0_valid", wb_valid, 1); chk("x0_we", wb_we, 0);

    drive(1, 32'h1, 5, 1, 1, 32'h100); cycle();
    chk("br_redir", redir_vld, 1); chk("br_pc", redir_pc, 32'h100); chk("br_we", wb_we, 0);
    drive(0, 0, 0, 0, 0, 0); cycle();
    chk("br_pulse", redir_vld, 0); chk("br_pc_hold", redir_pc, 32'h100);
    drive(1, 32'h0, 5, 1, 1, 32'h200); cycle();
    chk("nt_redir", redir_vld, 0); chk("nt_pc", redir_pc, 32'h100);

    // Flush with both entries full and a beat offered.
    wb_ready = 1'b0;
    drive(1, 32'h44, 6, 1, 0, 0); cycle();
    drive(1, 32'h55, 7, 1, 0, 0); cycle();
    flush = 1'b1; drive(1, 32'h77, 8, 1, 0, 0); cycle();
    chk("fl_valid", wb_valid, 0); chk("fl_ready", in_ready, 1);
    flush = 1'b0; drive(0, 0, 0, 0, 0, 0); cycle();
    chk("fl_dropped", wb_valid, 0);

    // Reset with full buffer and a redirect in flight.
    drive(1, 32'h66, 9, 1, 0, 0); cycle();
    drive(1, 32'h1, 0, 0, 1, 32'h300); cycle();
    chk("mr_redir_pend", redir_vld, 1);
    rst = 1'b1; drive(0, 0, 0, 0, 0, 0); cycle();
    chk("mr_valid", wb_valid, 0); chk("mr_ready", in_ready, 1); chk("mr_redir", redir_vld, 0);
    chk("mr_pc", redir_pc, 0); chk("mr_data", wb_data, 0); chk("mr_rd", wb_rd, 0);
`ifdef EX_WB_FWD_EN
    chk("mr_fwd", fwd_valid, 0);
`endif
    rst = 1'b0; wb_ready = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      wb_ready   = ($urandom_range(0, 2) != 0);
      alu_result = $urandom;
      rd         = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      we         = $urandom_range(0, 1);
      is_branch  = ($urandom_range(0, 5) == 0);
      target     = $urandom;
      flush      = ($urandom_range(0, 40) == 0);
      rst        = ($urandom_range(0, 150) == 0);
      cycle();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; wb_ready = 1'b1;
    cycle(); cycle();
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
